// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment constants and active-low hex segment table
package seg7_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF = 4'hF;
    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction
endpackage

// File: rtl/hex7seg_decoder.sv
// hex7seg_decoder: combinational nibble to active-low {g,f,e,d,c,b,a} decoder
module hex7seg_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit common-anode scan driver, double-buffered data (SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros)
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
    logic [CW-1:0] cnt;
    logic [15:0] pend_data, act_data;
    logic [3:0] pend_dp, act_dp, nib;
    logic [6:0] dec_seg;
    logic pend_valid, term, boundary, off, hide;
    assign term = cnt == TERM;
    assign boundary = term && digit_sel == 2'd3;
    assign frame_tick = boundary;
    assign nib = act_data[{digit_sel, 2'b00} +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic z3, z2, z1;
    assign z3 = act_data[15:12] == 4'd0;
    assign z2 = z3 && act_data[11:8] == 4'd0;
    assign z1 = z2 && act_data[7:4] == 4'd0;
    assign hide = digit_sel == 2'd3 ? z3 : digit_sel == 2'd2 ? z2 : digit_sel == 2'd1 ? z1 : 1'b0;
`else
    assign hide = 1'b0;
`endif
    assign off = cnt < BLANK || hide;
    hex7seg_decoder u_dec (
        .nibble(nib),
        .seg(dec_seg)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            digit_sel <= 2'd0;
            pend_data <= 16'd0;
            pend_dp <= 4'd0;
            pend_valid <= 1'b0;
            act_data <= 16'd0;
            act_dp <= 4'd0;
            an <= AN_OFF;
            seg <= SEG_BLANK;
            dp <= 1'b1;
        end else begin
            cnt <= term ? '0 : cnt + 1'b1;
            if (term)
                digit_sel <= digit_sel + 2'd1;
            if (wr_en) begin
                pend_data <= wr_data;
                pend_dp <= wr_dp;
            end
            pend_valid <= wr_en || (pend_valid && !boundary);
            if (boundary && pend_valid) begin
                act_data <= pend_data;
                act_dp <= pend_dp;
            end
            an <= off ? AN_OFF : ~(4'b0001 << digit_sel);
            seg <= off ? SEG_BLANK : dec_seg;
            dp <= off || !act_dp[digit_sel];
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan timing, double buffering, dp and async reset
module tb_seg7_scan_driver;
    logic clk, rst_n, wr_en, dp, frame_tick;
    logic [15:0] wr_data;
    logic [3:0] wr_dp, an;
    logic [6:0] seg;
    logic [1:0] digit_sel;
    int passed = 0;
    int total = 0;

    seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
        .an(an), .seg(seg), .dp(dp), .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [15:0] d, input logic [3:0] p);
        wr_data = d;
        wr_dp = p;
        wr_en = 1;
        @(posedge clk);
        #1 wr_en = 0;
    endtask

    task automatic chk_reset();
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_sel", 16'(digit_sel), 16'h0);
        chk("rst_tick", 16'(frame_tick), 16'h0);
    endtask

    // Waits for the boundary cycle, optionally writes on it, then steps past the boundary edge.
    task automatic align(input logic w, input logic [15:0] d, input logic [3:0] p);
        for (int n = 0; n < 64 && !frame_tick; n++) @(negedge clk);
        chk("tick_timeout", 16'(frame_tick), 16'h1);
        if (w) begin
            wr_data = d;
            wr_dp = p;
            wr_en = 1;
        end
        @(posedge clk);
        #1 wr_en = 0;
    endtask

    // segs = {slot3..slot0} codes, lit = decimal points lit, hide = slots kept dark.
    task automatic check_frame(input logic [27:0] segs, input logic [3:0] lit, input logic [3:0] hide,
                               input int wr_at, input logic [15:0] wd, input logic [3:0] wdp);
        logic [15:0] an_tab;
        logic off;
        int s;
        an_tab = 16'b0111_1011_1101_1110;
        for (int i = 0; i < 32; i++) begin
            if (i == wr_at) begin
                wr_data = wd;
                wr_dp = wdp;
                wr_en = 1;
            end
            @(posedge clk);
            #1 wr_en = 0;
            s = i / 8;
            off = (i % 8) < 2 || hide[s];
            chk($sformatf("an[%0d]", i), 16'(an), off ? 16'hF : 16'(an_tab[s*4 +: 4]));
            chk($sformatf("seg[%0d]", i), 16'(seg), off ? 16'h7F : 16'(segs[s*7 +: 7]));
            chk($sformatf("dp[%0d]", i), 16'(dp), off ? 16'h1 : 16'(!lit[s]));
            chk($sformatf("tick[%0d]", i), 16'(frame_tick), 16'(i == 30));
            chk($sformatf("sel[%0d]", i), 16'(digit_sel), 16'(((i + 1) / 8) % 4));
        end
    endtask

    initial begin
        rst_n = 0;
        wr_en = 1;
        wr_data = 16'h5555;
        wr_dp = 4'hF;
        repeat (3) @(posedge clk);
        #1 chk_reset();
        @(negedge clk);
        wr_en = 0;
        rst_n = 1;
        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, 4'b0000, 5, 16'h1234, 4'b0100);
        check_frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100, 4'b0000, -1, 16'h0, 4'h0);
        wr(16'hAAAA, 4'hF);
        wr(16'h00F0, 4'h0);
        align(1, 16'hFFFF, 4'h0);
        check_frame({7'h40, 7'h40, 7'h0E, 7'h40}, 4'b0000, 4'b0000, -1, 16'h0, 4'h0);
        check_frame({7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b0000, 4'b0000, -1, 16'h0, 4'h0);
        align(0, 16'h0, 4'h0);
        repeat (17) @(posedge clk);
        #1 wr(16'h9999, 4'hF);
        @(negedge clk);
        rst_n = 0;
        wr_en = 1;
        wr_data = 16'h5555;
        wr_dp = 4'hF;
        #1 chk_reset();
        @(negedge clk);
        wr_en = 0;
        rst_n = 1;
        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, 4'b0000, -1, 16'h0, 4'h0);
        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, 4'b0000, -1, 16'h0, 4'h0);
        wr(16'h0070, 4'h0);
        align(0, 16'h0, 4'h0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check_frame({7'h40, 7'h40, 7'h78, 7'h40}, 4'b0000, 4'b1100, -1, 16'h0, 4'h0);
`else
        check_frame({7'h40, 7'h40, 7'h78, 7'h40}, 4'b0000, 4'b0000, -1, 16'h0, 4'h0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a 4-digit common-anode seven-segment display. It holds four hex digits plus decimal points, walks the digit select 0→1→2→3 at a programmable refresh rate, and drives active-low anodes with a blanking gap per slot to suppress ghosting. It decodes the selected nibble to segments. It is the output-side counterpart of the digit-select mux: it generates the select and demultiplexes it onto the anodes. New data is double-buffered and committed only at a frame boundary, so the display never shows a partial update.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot; minimum 2.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
wr_en  input  1  one-cycle write strobe; accepted on any cycle
wr_data  input  16  digit3..digit0 as {[15:12],[11:8],[7:4],[3:0]}
wr_dp  input  4  decimal point per digit, 1 = lit
an  output  4  anode enables, active-low, an[i] = digit i
seg  output  7  {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
digit_sel  output  2  current slot index
frame_tick  output  1  one-cycle pulse on commit/frame boundary

Behaviour:
- Reset (async assert, sync release): an=4'hF, seg=7'h7F, dp=1, digit_sel=0, frame_tick=0, prescaler=0, active digits/dp=0, pending_valid=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. At terminal count, digit_sel increments modulo 4 (3→0 wraps).
- Frame boundary: terminal count while digit_sel==3.
  - frame_tick=1 for that cycle.
  - If pending_valid, pending data and dp are copied to active and pending_valid is cleared.
- wr_en loads wr_data/wr_dp into the pending register and sets pending_valid.
  - If several writes occur before a boundary, the last write wins.
  - A write on the boundary cycle goes to pending and is shown from the following frame, not the one just starting.
- Slot output, all outputs registered (1-cycle latency from prescaler/digit_sel state):
  - While prescaler < BLANK_CYCLES: an=4'hF, seg=7'h7F, dp=1.
  - Otherwise: an = ~(4'b0001 << digit_sel), seg = decode(active[digit_sel]), dp = ~active_dp[digit_sel].
- Decode table (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- rst_n asserted mid-scan or mid-write: all state returns to reset values immediately, and pending data is discarded.
- Asserting wr_en during reset has no effect.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: digits 3, 2 and 1 are suppressed when the digit and every higher digit in active equal 0. A suppressed digit keeps an high, seg=7F and dp=1 for its whole slot. Digit 0 is always shown. Slot timing and frame_tick are unchanged.
- Undefined: all four digits are always shown.

Decomposition:
- Package seg7_pkg:
  - constants SEG_BLANK=7'h7F, AN_OFF=4'hF, NUM_DIGITS=4;
  - the 16-entry segment code table as localparams;
  - function hex_to_seg(nibble) returning 7 bits.
- Sub-module hex7seg_decoder: combinational nibble→segment decoder using the package function, reused by other display blocks.
- Prescaler, slot FSM, double buffer and anode demux stay in seg7_scan_driver. Counter width is $clog2(REFRESH_DIV).

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2.
1. Scan timing, no writes → per slot, an = 1111 for 2 cycles then 1110 for 6 cycles; next slots 1101, 1011, 0111; seg=40 when unblanked; frame_tick every 32 cycles.
2. wr_en with 16'h1234 at cycle 5 → display unchanged until first frame_tick; next frame slot0 seg=19, slot1 seg=30, slot2 seg=24, slot3 seg=79.
3. wr_en 16'hAAAA, then 16'h00F0 before boundary; plus wr_en 16'hFFFF on the frame_tick cycle → frame shows 0,F,0,0 (digits 0..3); 16'hFFFF shows only the frame after that.
4. wr_dp=4'b0100 → dp=0 only in unblanked cycles of slot 2; dp=1 in blank cycles and other slots.
5. rst_n low for 1 cycle mid-slot 2 with a pending write → outputs reset asynchronously (an=F, seg=7F); after release, scan restarts at slot 0 and shows all zeros.
6. 16'h0070 committed → with SEG7_LEADING_ZERO_BLANK_EN: slots 3 and 2 keep an=1111, slot1 seg=78, slot0 seg=40. Without the macro: slots 3 and 2 show seg=40.
